n64a_vdemux: RTL and testbench

Front-end stage of the N64 video pipeline, clocked by VCLK. It demultiplexes the 4-phase N64 video bus into a complete per-pixel word and publishes the previous pixel as `vdata_pre`. It also produces the `data_cnt` phase counter and detects the video mode (PAL/NTSC) and 480i-vs-240p. Its outputs directly feed the deblur estimator and the rest of the PPU.

---
 rtl/n64a_vdemux_if.sv | 27 ++
 rtl/n64a_vdemux.sv | 97 +++++++++
 tb/tb_n64a_vdemux.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/n64a_vdemux_if.sv
// ============================================================================
// n64a_vdemux_if : N64 video bus in, assembled pixel and mode state out
// Rev 1.0
// ============================================================================
`default_nettype none

interface n64a_vdemux_if #(
    parameter int color_width_i = 7
);
    logic                         nVDSYNC;
    logic [color_width_i-1:0]     VD_i;
    logic [3*color_width_i+3:0]   vdata_pre;
    logic [3:0]                   vid_state_o;
    logic                         field_id_o;

    modport master (
        output nVDSYNC, VD_i,
        input  vdata_pre, vid_state_o, field_id_o
    );

    modport slave (
        input  nVDSYNC, VD_i,
        output vdata_pre, vid_state_o, field_id_o
    );
endinterface

`default_nettype wire

// File: rtl/n64a_vdemux.sv
// ============================================================================
// n64a_vdemux : 4-phase N64 video bus demux with PAL/NTSC and 480i detection
// Rev 1.0
// ============================================================================
`default_nettype none

module n64a_vdemux #(
    parameter int color_width_i = 7
) (
    input  wire logic       VCLK,
    input  wire logic       nRST,
    n64a_vdemux_if.slave    bus
);

    localparam int CW = color_width_i;
    localparam int DW = 3 * CW + 4;
    localparam logic [DW-1:0] PIX_RESET = {4'hF, {(3 * CW){1'b0}}};
    localparam logic [9:0]    LINE_MAX  = 10'd1023;
    localparam logic [9:0]    LINE_MIN  = 10'd200;
    localparam logic [9:0]    LINE_PAL  = 10'd280;

    logic [DW-1:0] acc_q,       acc_d;
    logic [DW-1:0] vdata_pre_q, vdata_pre_d;
    logic [1:0]    data_cnt_q,  data_cnt_d;
    logic [9:0]    line_cnt_q,  line_cnt_d;
    logic          vmode_q,     vmode_d;
    logic          n64_480i_q,  n64_480i_d;
    logic          field_id_q,  field_id_d;
    logic          vs_fall,     hs_fall;

    always_comb begin
        acc_d       = acc_q;
        vdata_pre_d = vdata_pre_q;
        data_cnt_d  = data_cnt_q + 2'd1;
        line_cnt_d  = line_cnt_q;
        vmode_d     = vmode_q;
        n64_480i_d  = n64_480i_q;
        field_id_d  = field_id_q;
        vs_fall     = 1'b0;
        hs_fall     = 1'b0;

        if (!bus.nVDSYNC) begin
            vdata_pre_d           = acc_q;
            acc_d[DW-1 -: 4]      = bus.VD_i[3:0];
            data_cnt_d            = 2'b01;
            // Edges compare against the published pixel's sync nibble
            vs_fall = vdata_pre_q[3*CW+3] & ~bus.VD_i[3];
            hs_fall = vdata_pre_q[3*CW+1] & ~bus.VD_i[1];

            if (vs_fall) begin
                line_cnt_d = '0;
                if (line_cnt_q >= LINE_MIN) begin
                    vmode_d    = (line_cnt_q > LINE_PAL);
                    field_id_d = bus.VD_i[1];
                    n64_480i_d = (bus.VD_i[1] != field_id_q);
                end
            end else if (hs_fall && (line_cnt_q != LINE_MAX)) begin
                line_cnt_d = line_cnt_q + 10'd1;
            end
        end else begin
            // data_cnt already points at the colour currently on the bus
            unique case (data_cnt_q)
                2'b01:   acc_d[3*CW-1 -: CW] = bus.VD_i;
                2'b10:   acc_d[2*CW-1 -: CW] = bus.VD_i;
                2'b11:   acc_d[CW-1:0]       = bus.VD_i;
                default: acc_d               = acc_q;
            endcase
        end
    end

    always_ff @(posedge VCLK) begin
        if (!nRST) begin
            acc_q       <= PIX_RESET;
            vdata_pre_q <= PIX_RESET;
            data_cnt_q  <= 2'b00;
            line_cnt_q  <= '0;
            vmode_q     <= 1'b0;
            n64_480i_q  <= 1'b0;
            field_id_q  <= 1'b1;
        end else begin
            acc_q       <= acc_d;
            vdata_pre_q <= vdata_pre_d;
            data_cnt_q  <= data_cnt_d;
            line_cnt_q  <= line_cnt_d;
            vmode_q     <= vmode_d;
            n64_480i_q  <= n64_480i_d;
            field_id_q  <= field_id_d;
        end
    end

    assign bus.vdata_pre   = vdata_pre_q;
    assign bus.vid_state_o = {data_cnt_q, vmode_q, n64_480i_q};
    assign bus.field_id_o  = field_id_q;

endmodule

`default_nettype wire

// File: tb/tb_n64a_vdemux.sv
// ============================================================================
// tb_n64a_vdemux : randomized stimulus checked against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_n64a_vdemux;

    logic VCLK = 1'b0;
    logic nRST = 1'b0;
    always #5 VCLK = ~VCLK;

    n64a_vdemux_if #(.color_width_i(7)) bus ();

    n64a_vdemux #(.color_width_i(7)) dut (
        .VCLK (VCLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: published pixel, pixel under assembly, phase count
    logic [3:0] m_out_s, m_cur_s;
    logic [6:0] m_out_r, m_out_g, m_out_b, m_cur_r, m_cur_g, m_cur_b;
    int         m_phase, m_lines;
    logic       m_vmode, m_i480, m_fid;

    always @(posedge VCLK) begin
        if (!nRST) begin
            m_out_s = 4'hF; m_out_r = 0; m_out_g = 0; m_out_b = 0;
            m_cur_s = 4'hF; m_cur_r = 0; m_cur_g = 0; m_cur_b = 0;
            m_phase = 0; m_lines = 0;
            m_vmode = 0; m_i480 = 0; m_fid = 1;
        end else if (!bus.nVDSYNC) begin
            if (m_out_s[3] && !bus.VD_i[3]) begin
                if (m_lines >= 200) begin
                    m_vmode = (m_lines > 280);
                    m_i480  = (bus.VD_i[1] != m_fid);
                    m_fid   = bus.VD_i[1];
                end
                m_lines = 0;
            end else if (m_out_s[1] && !bus.VD_i[1]) begin
                m_lines = (m_lines >= 1023) ? 1023 : m_lines + 1;
            end
            m_out_s = m_cur_s; m_out_r = m_cur_r; m_out_g = m_cur_g; m_out_b = m_cur_b;
            m_cur_s = bus.VD_i[3:0];
            m_phase = 1;
        end else begin
            case (m_phase % 4)
                1: m_cur_r = bus.VD_i;
                2: m_cur_g = bus.VD_i;
                3: m_cur_b = bus.VD_i;
                default: ;
            endcase
            m_phase = m_phase + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge VCLK) begin
        if (chk_en) begin
            logic [1:0] dc;
            dc = 2'(m_phase % 4);
            chk("vdata_pre", 32'(bus.vdata_pre), 32'({m_out_s, m_out_r, m_out_g, m_out_b}));
            chk("vid_state", 32'(bus.vid_state_o), 32'({dc, m_vmode, m_i480}));
            chk("field_id", 32'(bus.field_id_o), 32'(m_fid));
        end
    end

    task automatic step(input logic rn, input logic nv, input logic [6:0] vd);
        nRST        = rn;
        bus.nVDSYNC = nv;
        bus.VD_i    = vd;
        @(posedge VCLK);
        #1;
    endtask

    task automatic pixel(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
        step(1'b1, 1'b0, {3'($urandom_range(0, 7)), s});
        step(1'b1, 1'b1, r);
        step(1'b1, 1'b1, g);
        step(1'b1, 1'b1, b);
    endtask

    task automatic rpix(input logic vs, input logic hs);
        pixel({vs, 1'b1, hs, 1'b1}, 7'($urandom), 7'($urandom), 7'($urandom));
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            rpix(1'b1, 1'b0);
            rpix(1'b1, 1'b1);
            rpix(1'b1, 1'b1);
        end
    endtask

    task automatic mode_chk(input string nm, input logic vm, input logic i4, input logic fid);
        chk({nm, "_vmode"}, 32'(bus.vid_state_o[1]), 32'(vm));
        chk({nm, "_480i"},  32'(bus.vid_state_o[0]), 32'(i4));
        chk({nm, "_fid"},   32'(bus.field_id_o),    32'(fid));
    endtask

    initial begin
        bus.nVDSYNC = 1'b1;
        bus.VD_i    = '0;

        // Reset and assembly
        step(1'b0, 1'b1, 7'h00);
        chk_en = 1'b1;
        step(1'b0, 1'b1, 7'h00);
        step(1'b0, 1'b1, 7'h00);
        chk("rst_vdata", 32'(bus.vdata_pre), 32'h01E0_0000);
        chk("rst_dcnt",  32'(bus.vid_state_o), 32'h0);
        chk("rst_fid",   32'(bus.field_id_o), 32'h1);
        step(1'b1, 1'b0, 7'h0F);
        chk("dcnt_s", 32'(bus.vid_state_o[3:2]), 32'h1);
        step(1'b1, 1'b1, 7'h11);
        chk("dcnt_r", 32'(bus.vid_state_o[3:2]), 32'h2);
        step(1'b1, 1'b1, 7'h22);
        chk("dcnt_g", 32'(bus.vid_state_o[3:2]), 32'h3);
        step(1'b1, 1'b1, 7'h33);
        chk("dcnt_b", 32'(bus.vid_state_o[3:2]), 32'h0);
        step(1'b1, 1'b0, 7'h0F);
        chk("pix1", 32'(bus.vdata_pre), 32'({4'hF, 7'h11, 7'h22, 7'h33}));
        step(1'b1, 1'b1, 7'h44);
        step(1'b1, 1'b1, 7'h55);
        step(1'b1, 1'b1, 7'h66);

        // NTSC progressive: three 263-line fields
        lines(5);
        rpix(1'b0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            lines(263);
            rpix(1'b0, 1'b1);
        end
        mode_chk("ntsc", 1'b0, 1'b0, 1'b1);

        // Glitch field: short field must not change mode or field id
        lines(50);
        rpix(1'b0, 1'b0);
        mode_chk("glitch", 1'b0, 1'b0, 1'b1);
        lines(263);
        rpix(1'b0, 1'b0);
        mode_chk("after_glitch", 1'b0, 1'b1, 1'b0);

        // PAL interlaced: 312-line fields with alternating field parity
        lines(312);
        rpix(1'b0, 1'b1);
        mode_chk("pal1", 1'b1, 1'b1, 1'b1);
        lines(312);
        rpix(1'b0, 1'b0);
        mode_chk("pal2", 1'b1, 1'b1, 1'b0);

        // Simultaneous vs/hs above cleared the count: 280 lines is still NTSC
        lines(280);
        rpix(1'b0, 1'b1);
        mode_chk("b280", 1'b0, 1'b1, 1'b1);
        lines(281);
        rpix(1'b0, 1'b1);
        mode_chk("b281", 1'b1, 1'b0, 1'b1);
        lines(199);
        rpix(1'b0, 1'b0);
        mode_chk("b199", 1'b1, 1'b0, 1'b1);
        lines(200);
        rpix(1'b0, 1'b0);
        mode_chk("b200", 1'b0, 1'b1, 1'b0);

        // Saturation: 1100 lines without vsync
        lines(1100);
        rpix(1'b0, 1'b0);
        mode_chk("sat", 1'b1, 1'b0, 1'b0);

        // Random bus: arbitrary sync nibbles, irregular pixel lengths
        for (int i = 0; i < 400; i++) begin
            int k;
            k = $urandom_range(1, 5);
            step(1'b1, 1'b0, 7'($urandom));
            for (int j = 0; j < k; j++) step(1'b1, 1'b1, 7'($urandom));
        end

        // Mid-frame reset during G phase
        step(1'b1, 1'b0, 7'h0F);
        step(1'b1, 1'b1, 7'h12);
        step(1'b0, 1'b1, 7'h34);
        chk("mrst_vdata", 32'(bus.vdata_pre), 32'h01E0_0000);
        chk("mrst_state", 32'(bus.vid_state_o), 32'h0);
        chk("mrst_fid",   32'(bus.field_id_o), 32'h1);
        step(1'b1, 1'b1, 7'h56);
        step(1'b1, 1'b0, 7'h0F);
        chk("mrst_first", 32'(bus.vdata_pre), 32'h01E0_0000);
        step(1'b1, 1'b1, 7'h55);
        step(1'b1, 1'b1, 7'h2A);
        step(1'b1, 1'b1, 7'h7F);
        step(1'b1, 1'b0, 7'h0B);
        chk("mrst_pix", 32'(bus.vdata_pre), 32'({4'hF, 7'h55, 7'h2A, 7'h7F}));
        step(1'b1, 1'b1, 7'h01);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
